uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver for 8N1-style frames, with a configurable data width. It consumes the 16x oversample tick from the baud generator and synchronises the asynchronous serial input. It validates the start bit at mid-bit, then samples each data bit and the stop bit at its centre. It presents the received byte with a one-cycle valid pulse, or a one-cycle frame-error pulse, to the host logic.

Parameters:
DATA_BITS, 8, number of data bits per frame, sent LSB first; legal range 5..9.
OVERSAMPLE, 16, tick2 pulses per bit period; must be a power of 2 and at least 4; must match the baud generator's oversample ratio.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset (logic reset while rst==0).
baud_tick2  input  1  oversample tick; one-clk pulse, OVERSAMPLE per bit period.
rx  input  1  serial line; idle high; asynchronous to clk.
rx_data  output  DATA_BITS  last correctly framed word; held until the next good frame.
rx_valid  output  1  one-clk pulse: rx_data updated this cycle.
frame_err  output  1  one-clk pulse: stop bit sampled low; frame discarded.
rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst==0, asynchronous):
  - rx_data=0, rx_valid=0, frame_err=0, rx_busy=0.
  - FSM=IDLE; tick_cnt=0, bit_idx=0, shift register=0.
  - Both synchroniser flops = 1 (idle level), so no false start on reset release.
- Input sync: rx passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s only.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits wide and wraps naturally.
  - bit_idx is $clog2(DATA_BITS) bits wide (minimum 1).
- FSM state and counters advance only on clk edges where baud_tick2==1. With no tick, all state is frozen.
- Definitions: MID = OVERSAMPLE/2-1 (7 at default). LAST = OVERSAMPLE-1 (15).
- IDLE:
  - On a tick with rx_s==0: go to START, tick_cnt<=0.
  - rx_busy goes high the cycle after that tick.
- START, per tick:
  - If tick_cnt==MID and rx_s==0: go to DATA, tick_cnt<=0, bit_idx<=0.
  - If tick_cnt==MID and rx_s==1: glitch; go to IDLE silently, with no output pulse.
  - Otherwise: tick_cnt++.
- DATA, per tick:
  - If tick_cnt==LAST: shift rx_s into the MSB of the shift register (shift right, so LSB-first order ends aligned), tick_cnt<=0.
    - If bit_idx==DATA_BITS-1: go to STOP.
    - Otherwise: bit_idx++.
  - Otherwise: tick_cnt++.
- STOP, per tick:
  - If tick_cnt==LAST and rx_s==1: rx_data<=shift register, rx_valid<=1 for exactly one clk, go to IDLE.
  - If tick_cnt==LAST and rx_s==0: frame_err<=1 for one clk, rx_data unchanged, rx_valid stays 0, go to IDLE.
  - Otherwise: tick_cnt++.
- Latency: rx_valid or frame_err rises one clk after the stop-bit centre tick, about 0.5 bit period before the nominal end of the stop bit. This allows back-to-back frames with one stop bit.
- rx_valid and frame_err are never high in the same cycle. Both are 0 on every other cycle.
- No overrun detection: every good frame pulses rx_valid and overwrites rx_data, whether or not the host has consumed the previous word.
- Line held low (break): each frame-length period yields frame_err with no rx_valid. This is accepted behaviour; there is no dedicated break detection.
- Reset asserted mid-frame: immediate return to the reset values above. The partial frame is lost and no pulse is generated.
- Simultaneous events: a tick on the same edge as the IDLE-return is consumed by the transition. Start detection resumes on the next tick.

Test Plan:
- Good frame: clk=50 MHz, tick2 every 325 clks, send 0x55 at 9600 baud → one rx_valid pulse, rx_data=0x55, frame_err never 1, rx_busy low after the pulse.
- Framing error: after 0x55, send 0xA3 with stop bit=0 → one frame_err pulse, no rx_valid, rx_data remains 0x55.
- Glitch rejection: drive rx low for 4 tick periods, then high → rx_busy pulses high then returns low; no rx_valid, no frame_err.
- Back-to-back frames: 0x00 then 0xFF with a single stop bit and no idle gap → exactly two rx_valid pulses, carrying 0x00 then 0xFF.
- Reset mid-frame: pull rst low during data bit 3 → all outputs 0 asynchronously. After release, send 0x3C → rx_data=0x3C with one rx_valid.
- Tick stall: hold baud_tick2=0 for 1000 clks mid-frame (rx stable) → no state change. When ticks resume and the frame completes, the correct byte is received.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampled UART receiver (start / DATA_BITS / one stop bit).
//               Synchronises rx, validates the start bit at mid-bit, samples
//               each data bit and the stop bit at its centre, and produces a
//               one-clock valid or frame-error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick2,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] C_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] C_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_TOP  = BW'(DATA_BITS - 1);

  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_rx: DATA_BITS must be in 5..9");
  end
  if ((OVERSAMPLE < 4) || ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0)) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be a power of 2 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [1:0]           sync_q;
  logic                 rx_s;

  // Two-flop synchroniser, preset to the idle level so reset release cannot look like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic: everything holds unless a tick arrives; pulses default low every clock
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (baud_tick2) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end

        S_START: begin
          if (tick_cnt_q == C_MID) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end else begin
              // Start bit did not survive to mid-bit: treat as noise
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        S_DATA: begin
          if (tick_cnt_q == C_LAST) begin
            // LSB arrives first, so shifting right leaves it in bit 0 at the end
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            if (bit_idx_q == C_TOP) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        S_STOP: begin
          if (tick_cnt_q == C_LAST) begin
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            if (rx_s) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. A serial driver produces
//               frames with real-time bit periods; a monitor collects every
//               output pulse and the scenario tasks compare against a
//               frame-level expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int DATA_BITS = 8;
  localparam int OS        = 16;
  localparam int TP        = 4;          // clocks per oversample tick
  localparam int BIT       = OS * TP;    // clocks per bit period

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 baud_tick2 = 1'b0;
  logic                 rx = 1'b1;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 rx_busy;

  int compared   = 0;
  int mismatched = 0;

  // Monitor state
  int                   valid_cnt = 0;
  int                   ferr_cnt  = 0;
  logic [DATA_BITS-1:0] got_q[$];
  bit                   both_seen   = 1'b0;
  bit                   busy_seen   = 1'b0;
  bit                   stall_watch = 1'b0;
  bit                   stall_drop  = 1'b0;
  int                   stall_pulses = 0;

  // Tick generator state
  bit tick_en = 1'b1;
  int tcnt    = 0;

  uart_rx #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick2(baud_tick2),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // Free-running oversample tick, one clock wide every TP clocks, gated by tick_en
  always @(negedge clk) begin
    tcnt       = (tcnt == TP - 1) ? 0 : tcnt + 1;
    baud_tick2 = tick_en && (tcnt == 0);
  end

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      got_q.push_back(rx_data);
    end
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_seen = 1'b1;
    if (rx_busy) busy_seen = 1'b1;
    if (stall_watch) begin
      if (!rx_busy) stall_drop = 1'b1;
      if (rx_valid || frame_err) stall_pulses++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame: start, LSB-first data, one stop bit of the given level.
  // stall_bit >= 0 freezes the ticks for 1000 clocks in the middle of that data bit.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_b, input int stall_bit);
    @(negedge clk);
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      if (i == stall_bit) begin
        wait_clks(BIT / 2);
        tick_en     = 1'b0;
        stall_watch = 1'b1;
        wait_clks(1000);
        stall_watch = 1'b0;
        tick_en     = 1'b1;
        wait_clks(BIT - BIT / 2);
      end else begin
        wait_clks(BIT);
      end
    end
    rx = stop_b;
    wait_clks(BIT);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_clks(5);
    compared++;
    if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    compared++;
    if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    compared++;
    if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    compared++;
    if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
    rst = 1'b1;
    wait_clks(3 * BIT);
    compared++;
    if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL reset_release_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_good_frame();
    int v0, f0;
    got_q.delete();
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, -1);
    wait_clks(BIT);
    compared++;
    if (valid_cnt - v0 != 1) begin mismatched++; $display("FAIL good_valid_count: got %0d want 1", valid_cnt - v0); end
    compared++;
    if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
      mismatched++; $display("FAIL good_pulse_data: got %0d words, first %h want 55", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    compared++;
    if (rx_data !== 8'h55) begin mismatched++; $display("FAIL good_rx_data: got %h want 55", rx_data); end
    compared++;
    if (ferr_cnt != f0) begin mismatched++; $display("FAIL good_no_ferr: got %0d want 0", ferr_cnt - f0); end
    compared++;
    if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL good_busy_after: got %b want 0", rx_busy); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA3, 1'b0, -1);
    wait_clks(2 * BIT);
    compared++;
    if (ferr_cnt - f0 != 1) begin mismatched++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
    compared++;
    if (valid_cnt != v0) begin mismatched++; $display("FAIL ferr_no_valid: got %0d want 0", valid_cnt - v0); end
    compared++;
    if (rx_data !== 8'h55) begin mismatched++; $display("FAIL ferr_data_held: got %h want 55", rx_data); end
    compared++;
    if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL ferr_busy_after: got %b want 0", rx_busy); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    @(negedge clk);
    busy_seen = 1'b0;
    rx = 1'b0;
    wait_clks(4 * TP);
    rx = 1'b1;
    wait_clks(20 * TP);
    compared++;
    if (busy_seen !== 1'b1) begin mismatched++; $display("FAIL glitch_busy_pulse: got %b want 1", busy_seen); end
    compared++;
    if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL glitch_busy_after: got %b want 0", rx_busy); end
    compared++;
    if (valid_cnt != v0 || ferr_cnt != f0) begin
      mismatched++; $display("FAIL glitch_no_pulse: got valid %0d ferr %0d want 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    got_q.delete();
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_clks(BIT);
    compared++;
    if (valid_cnt - v0 != 2) begin mismatched++; $display("FAIL b2b_count: got %0d want 2", valid_cnt - v0); end
    compared++;
    if (got_q.size() < 1 || got_q[0] !== 8'h00) begin
      mismatched++; $display("FAIL b2b_first: got %h want 00", (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    compared++;
    if (got_q.size() < 2 || got_q[1] !== 8'hFF) begin
      mismatched++; $display("FAIL b2b_second: got %h want ff", (got_q.size() > 1) ? got_q[1] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int v0, f0;
    d = 8'hA5;
    v0 = valid_cnt; f0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      wait_clks(BIT);
    end
    rx = d[3];
    wait_clks(BIT / 2);
    #2 rst = 1'b0;
    #1;
    compared++;
    if (rx_data !== 8'h00) begin mismatched++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
    compared++;
    if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_rx_busy: got %b want 0", rx_busy); end
    compared++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
      mismatched++; $display("FAIL rstmid_pulses: got valid %b ferr %b want 0 0", rx_valid, frame_err);
    end
    wait_clks(3);
    rx = 1'b1;
    wait_clks(BIT);
    rst = 1'b1;
    wait_clks(2 * BIT);
    compared++;
    if (valid_cnt != v0 || ferr_cnt != f0) begin
      mismatched++; $display("FAIL rstmid_no_pulse: got valid %0d ferr %0d want 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
    got_q.delete();
    send_frame(8'h3C, 1'b1, -1);
    wait_clks(BIT);
    compared++;
    if (valid_cnt - v0 != 1) begin mismatched++; $display("FAIL rstmid_after_count: got %0d want 1", valid_cnt - v0); end
    compared++;
    if (rx_data !== 8'h3C) begin mismatched++; $display("FAIL rstmid_after_data: got %h want 3c", rx_data); end
  endtask

  task automatic test_tick_stall();
    int v0;
    got_q.delete();
    v0 = valid_cnt;
    stall_drop   = 1'b0;
    stall_pulses = 0;
    send_frame(8'hC6, 1'b1, 3);
    wait_clks(BIT);
    compared++;
    if (stall_drop !== 1'b0) begin mismatched++; $display("FAIL stall_busy_held: got drop %b want 0", stall_drop); end
    compared++;
    if (stall_pulses != 0) begin mismatched++; $display("FAIL stall_no_pulse: got %0d want 0", stall_pulses); end
    compared++;
    if (valid_cnt - v0 != 1 || rx_data !== 8'hC6) begin
      mismatched++; $display("FAIL stall_data: got count %0d data %h want 1 c6", valid_cnt - v0, rx_data);
    end
  endtask

  // Random frames: good frames must come back in order, bad-stop frames only count errors
  task automatic test_random();
    logic [DATA_BITS-1:0] exp_q[$];
    logic [DATA_BITS-1:0] d;
    logic [DATA_BITS-1:0] last_good;
    logic                 stop_b;
    int                   exp_ferr;
    int                   f0;
    exp_ferr  = 0;
    last_good = rx_data_expected_seed();
    got_q.delete();
    f0 = ferr_cnt;
    for (int n = 0; n < 8; n++) begin
      d      = DATA_BITS'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      if (stop_b) begin
        exp_q.push_back(d);
        last_good = d;
      end else begin
        exp_ferr++;
      end
      send_frame(d, stop_b, -1);
      wait_clks(BIT * $urandom_range(1, 3));
    end
    compared++;
    if (got_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      compared++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        mismatched++; $display("FAIL rand_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    compared++;
    if (ferr_cnt - f0 != exp_ferr) begin mismatched++; $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt - f0, exp_ferr); end
    compared++;
    if (rx_data !== last_good) begin mismatched++; $display("FAIL rand_last_data: got %h want %h", rx_data, last_good); end
  endtask

  // Word left in rx_data by the preceding scenario (stall test received 0xC6)
  function automatic logic [DATA_BITS-1:0] rx_data_expected_seed();
    return 8'hC6;
  endfunction

  task automatic test_exclusive_pulses();
    compared++;
    if (both_seen !== 1'b0) begin mismatched++; $display("FAIL exclusive_pulses: got both-high %b want 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_tick_stall();
    test_random();
    test_exclusive_pulses();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
